// File: rtl/cnn_isa_pkg.sv
// Shared ISA definitions for the vector execution blocks:
// opcode and sequencer state encodings.
package cnn_isa_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_MAX  = 2'b00,
    OP_MIN  = 2'b01,
    OP_RELU = 2'b10,
    OP_ILL  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/vmax_lane.sv
// One signed lane of the max/min/relu datapath; purely combinational.
// On equal operands the src1 value (a_i) is returned.
module vmax_lane
  import cnn_isa_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  op_e                      op_i,
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [DATA_W-1:0] b_i,
  output logic signed [DATA_W-1:0] y_o
);

  always_comb begin
    y_o = a_i;
    case (op_i)
      OP_MAX:  if (b_i > a_i) y_o = b_i;
      OP_MIN:  if (b_i < a_i) y_o = b_i;
      OP_RELU: if (a_i[DATA_W-1]) y_o = '0;
      default: y_o = a_i;
    endcase
  end

endmodule

// File: rtl/vmax_exec.sv
// Vector max/min/relu executor: internal register file, one instruction at a
// time, PAR lanes per beat, host load/readback port.
module vmax_exec
  import cnn_isa_pkg::*;
#(
  parameter  int DATA_W = 16,
  parameter  int LANES  = 32,
  parameter  int NREG   = 16,
  parameter  int PAR    = 8,
  localparam int RW     = $clog2(NREG),
  localparam int IW     = OP_W + 3 * RW,
  localparam int VW     = LANES * DATA_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inst_valid,
  output logic          inst_ready,
  input  logic [IW-1:0] inst,
  input  logic          wr_en,
  input  logic [RW-1:0] wr_addr,
  input  logic [VW-1:0] wr_data,
  input  logic [RW-1:0] rd_addr,
  output logic [VW-1:0] rd_data,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          wr_drop
);

  localparam int NBEAT = LANES / PAR;
  localparam int PW    = PAR * DATA_W;
  localparam int BW    = (NBEAT > 1) ? $clog2(NBEAT) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(NBEAT - 1);

  state_e        state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  op_e           op_q;
  logic [RW-1:0] src1_q, src2_q, dst_q;
  logic [VW-1:0] regs_q [NREG];
  logic [VW-1:0] rd_data_q;
  logic          wr_drop_q;

  logic          accept, hostWr, execWr;
  logic [PW-1:0] chunkA, chunkB, chunkY;

  assign inst_ready = (state_q == ST_IDLE);
  assign accept     = inst_valid && inst_ready;
  assign hostWr     = wr_en && inst_ready && !accept;
  assign execWr     = (state_q == ST_EXEC) && (op_q != OP_ILL);

  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_DONE);
  assign err     = done && (op_q == OP_ILL);
  assign wr_drop = wr_drop_q;
  assign rd_data = rd_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_EXEC;
          beat_d  = '0;
        end
      end
      ST_EXEC: begin
        if (beat_q == LAST_BEAT) begin
          state_d = ST_DONE;
          beat_d  = '0;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= OP_MAX;
      src1_q <= '0;
      src2_q <= '0;
      dst_q  <= '0;
    end else if (accept) begin
      op_q   <= op_e'(inst[IW-1 -: OP_W]);
      src1_q <= inst[3*RW-1 -: RW];
      src2_q <= inst[2*RW-1 -: RW];
      dst_q  <= inst[RW-1:0];
    end
  end

  // Each beat reads and writes only its own lane chunk, so aliased dst is safe.
  assign chunkA = regs_q[src1_q][int'(beat_q)*PW +: PW];
  assign chunkB = regs_q[src2_q][int'(beat_q)*PW +: PW];

  for (genvar g = 0; g < PAR; g++) begin : g_lane
    vmax_lane #(.DATA_W(DATA_W)) u_lane (
      .op_i (op_q),
      .a_i  (chunkA[g*DATA_W +: DATA_W]),
      .b_i  (chunkB[g*DATA_W +: DATA_W]),
      .y_o  (chunkY[g*DATA_W +: DATA_W])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) regs_q[r] <= '0;
    end else begin
      if (hostWr) regs_q[wr_addr] <= wr_data;
      if (execWr) regs_q[dst_q][int'(beat_q)*PW +: PW] <= chunkY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      rd_data_q <= regs_q[rd_addr];
      wr_drop_q <= wr_en && !hostWr;
    end
  end

endmodule

// File: tb/tb_vmax_exec.sv
// Randomized self-checking bench for vmax_exec against a whole-vector
// reference model, plus directed cases for aliasing, ties, drops and reset.
module tb_vmax_exec;

  localparam int DATA_W = 16;
  localparam int LANES  = 32;
  localparam int NREG   = 16;
  localparam int PAR    = 8;
  localparam int RW     = 4;
  localparam int IW     = 2 + 3 * RW;
  localparam int VW     = LANES * DATA_W;
  localparam int NBEAT  = LANES / PAR;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          inst_valid = 1'b0;
  logic          inst_ready;
  logic [IW-1:0] inst = '0;
  logic          wr_en = 1'b0;
  logic [RW-1:0] wr_addr = '0;
  logic [VW-1:0] wr_data = '0;
  logic [RW-1:0] rd_addr = '0;
  logic [VW-1:0] rd_data;
  logic          busy, done, err, wr_drop;

  int checks = 0;
  int errors = 0;

  logic signed [DATA_W-1:0] model [NREG][LANES];

  vmax_exec #(.DATA_W(DATA_W), .LANES(LANES), .NREG(NREG), .PAR(PAR)) dut (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done),
    .err(err), .wr_drop(wr_drop)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [VW-1:0] observed,
                             input logic [VW-1:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [VW-1:0] packReg(input int r);
    logic [VW-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*DATA_W +: DATA_W] = model[r][i];
    return v;
  endfunction

  function automatic void setModel(input int r, input logic [VW-1:0] v);
    for (int i = 0; i < LANES; i++) model[r][i] = v[i*DATA_W +: DATA_W];
  endfunction

  function automatic void clearModel();
    for (int r = 0; r < NREG; r++) setModel(r, '0);
  endfunction

  // Whole-vector semantics: all sources read before the destination is written.
  function automatic void applyModel(input int op, input int s1, input int s2, input int d);
    logic signed [DATA_W-1:0] res [LANES];
    int a, b;
    if (op == 3) return;
    for (int i = 0; i < LANES; i++) begin
      a = model[s1][i];
      b = model[s2][i];
      case (op)
        0:       res[i] = DATA_W'((a >= b) ? a : b);
        1:       res[i] = DATA_W'((a <= b) ? a : b);
        default: res[i] = DATA_W'((a > 0) ? a : 0);
      endcase
    end
    for (int i = 0; i < LANES; i++) model[d][i] = res[i];
  endfunction

  function automatic logic [VW-1:0] randVec();
    logic [VW-1:0] v;
    for (int i = 0; i < VW / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic hostWrite(input int r, input logic [VW-1:0] v);
    @(negedge clk);
    wr_en = 1'b1;
    wr_addr = RW'(r);
    wr_data = v;
    @(negedge clk);
    wr_en = 1'b0;
    checkOutput("wr_drop_idle", wr_drop, 1'b0);
    setModel(r, v);
  endtask

  task automatic checkReg(input int r);
    @(negedge clk);
    rd_addr = RW'(r);
    @(negedge clk);
    checkOutput($sformatf("reg_r%0d", r), rd_data, packReg(r));
  endtask

  // dropAt: -1 none, 0 host write coincident with accept, n>0 host write n cycles after the offer.
  task automatic applyStimulus(input logic [1:0] op, input int s1, input int s2, input int d,
                               input int dropAt, input logic [VW-1:0] dropData);
    int doneAt, busyCnt;
    logic errSeen;
    doneAt = -1;
    busyCnt = 0;
    errSeen = 1'b0;
    @(negedge clk);
    checkOutput("inst_ready_idle", inst_ready, 1'b1);
    inst = {op, RW'(s1), RW'(s2), RW'(d)};
    inst_valid = 1'b1;
    if (dropAt == 0) begin
      wr_en = 1'b1;
      wr_addr = RW'(d);
      wr_data = dropData;
    end
    for (int j = 1; j <= NBEAT + 6 && doneAt < 0; j++) begin
      @(negedge clk);
      inst_valid = 1'b0;
      if (dropAt >= 0 && j == dropAt + 1) begin
        checkOutput("wr_drop_pulse", wr_drop, 1'b1);
        wr_en = 1'b0;
      end
      if (dropAt > 0 && j == dropAt) begin
        wr_en = 1'b1;
        wr_addr = RW'(d);
        wr_data = dropData;
      end
      if (busy) busyCnt++;
      if (done) begin
        doneAt = j - 1;
        errSeen = err;
      end
    end
    checkOutput("done_latency", doneAt, NBEAT);
    checkOutput("busy_cycles", busyCnt, NBEAT + 1);
    checkOutput("err_with_done", errSeen, (op == 2'b11));
    @(negedge clk);
    checkOutput("done_pulse_end", {done, err, busy}, 3'b000);
    checkOutput("inst_ready_after", inst_ready, 1'b1);
    applyModel(op, s1, s2, d);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [VW-1:0] v, expVec;
    clearModel();
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", {busy, done, err, wr_drop}, 4'b0000);
    checkOutput("reset_rd_data", rd_data, '0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_inst_ready", inst_ready, 1'b1);
    checkReg(7);

    // MAX of constant vectors.
    for (int i = 0; i < LANES; i++) v[i*DATA_W +: DATA_W] = 16'sd5;
    hostWrite(1, v);
    for (int i = 0; i < LANES; i++) v[i*DATA_W +: DATA_W] = -16'sd3;
    hostWrite(2, v);
    applyStimulus(2'b00, 1, 2, 3, -1, '0);
    for (int i = 0; i < LANES; i++) expVec[i*DATA_W +: DATA_W] = 16'sd5;
    rd_addr = 4'd3;
    @(negedge clk);
    checkOutput("max_const", rd_data, expVec);

    // RELU in place: dst aliases src1.
    for (int i = 0; i < LANES; i++) v[i*DATA_W +: DATA_W] = DATA_W'(i - 16);
    hostWrite(1, v);
    applyStimulus(2'b10, 1, 2, 1, -1, '0);
    for (int i = 0; i < LANES; i++) expVec[i*DATA_W +: DATA_W] = DATA_W'((i < 16) ? 0 : i - 16);
    rd_addr = 4'd1;
    @(negedge clk);
    checkOutput("relu_alias", rd_data, expVec);

    // Extreme signed values.
    for (int i = 0; i < LANES; i++) v[i*DATA_W +: DATA_W] = 16'h8000;
    hostWrite(4, v);
    for (int i = 0; i < LANES; i++) v[i*DATA_W +: DATA_W] = 16'h7FFF;
    hostWrite(5, v);
    applyStimulus(2'b01, 4, 5, 6, -1, '0);
    applyStimulus(2'b01, 5, 4, 7, -1, '0);
    applyStimulus(2'b00, 4, 5, 8, -1, '0);
    for (int i = 0; i < LANES; i++) expVec[i*DATA_W +: DATA_W] = 16'h8000;
    rd_addr = 4'd6;
    @(negedge clk);
    checkOutput("min_extreme_a", rd_data, expVec);
    rd_addr = 4'd7;
    @(negedge clk);
    checkOutput("min_extreme_b", rd_data, expVec);
    for (int i = 0; i < LANES; i++) expVec[i*DATA_W +: DATA_W] = 16'h7FFF;
    rd_addr = 4'd8;
    @(negedge clk);
    checkOutput("max_extreme", rd_data, expVec);

    // Illegal opcode leaves everything untouched.
    applyStimulus(2'b11, 4, 5, 3, -1, '0);
    for (int r = 0; r < NREG; r++) checkReg(r);

    // Dropped host writes, coincident with accept and during execution.
    applyStimulus(2'b00, 1, 2, 9, 2, randVec());
    checkReg(9);
    applyStimulus(2'b01, 1, 2, 10, 0, randVec());
    checkReg(10);

    // Random mix of loads and instructions, including aliasing and illegal ops.
    for (int it = 0; it < 60; it++) begin
      int s1, s2, d, dropAt;
      s1 = $urandom_range(0, NREG - 1);
      s2 = ($urandom_range(0, 3) == 0) ? s1 : $urandom_range(0, NREG - 1);
      d  = ($urandom_range(0, 3) == 0) ? s2 : $urandom_range(0, NREG - 1);
      dropAt = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 3) : -1;
      if ($urandom_range(0, 2) == 0) begin
        hostWrite(d, randVec());
      end else begin
        applyStimulus(2'($urandom_range(0, 3)), s1, s2, d, dropAt, randVec());
      end
      checkReg(d);
    end
    for (int r = 0; r < NREG; r++) checkReg(r);

    // Reset while in EXEC beat 2 aborts and clears everything.
    @(negedge clk);
    inst = {2'b00, 4'd1, 4'd2, 4'd3};
    inst_valid = 1'b1;
    @(negedge clk);
    inst_valid = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("busy_before_reset", busy, 1'b1);
    rst = 1'b1;
    #1;
    checkOutput("reset_mid_exec", {busy, done, err}, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_reset", {inst_ready, busy, done}, 3'b100);
    clearModel();
    for (int r = 0; r < NREG; r++) checkReg(r);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vmax_exec.md
VMAX_EXEC -- requirements
Module: vmax_exec

Interface
REQ-001 Parameter DATA_W, default 16: signed element width in bits.
REQ-002 Parameter LANES, default 32: elements per vector register.
REQ-003 Parameter NREG, default 16: number of vector registers (power of 2).
REQ-004 Parameter PAR, default 8: lanes processed per cycle; LANES % PAR == 0; NBEAT = LANES/PAR.
REQ-005 One clock; reset is asynchronous and active-high.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  async active-high reset.
REQ-008 inst_valid  in  1  instruction offered.
REQ-009 inst_ready  out  1  block can accept instruction.
REQ-010 inst  in  2+3*RW (RW=log2 NREG)  {op[1:0], src1, src2, dst}, src1 in MSBs after op.
REQ-011 wr_en / wr_addr / wr_data  in  1 / RW / LANES*DATA_W  host vector register load.
REQ-012 rd_addr  in  RW; rd_data  out  LANES*DATA_W  host readback.
REQ-013 busy  out  1; done  out  1 (pulse); err  out  1 (pulse, valid with done); wr_drop  out  1 (pulse).

Function
REQ-014 Opcodes SHALL be: 00 MAX(src1,src2), 01 MIN(src1,src2), 10 RELU(src1)=max(src1,0) ignoring src2, 11 illegal.
REQ-015 Comparisons SHALL be signed two's-complement per lane; ties yield src1 value; no width growth.
REQ-016 FSM states SHALL be IDLE, EXEC, DONE; IDLE->EXEC on accept, EXEC->DONE after beat NBEAT-1, DONE->IDLE after one cycle.
REQ-017 Accept SHALL occur when inst_valid && inst_ready; inst_ready SHALL be 1 only in IDLE; inst latched on accept.
REQ-018 In EXEC beat k (0..NBEAT-1) the block SHALL read lanes [k*PAR, k*PAR+PAR-1] of src1/src2 and write results to same lanes of dst at that clock edge.
REQ-019 dst equal to src1 and/or src2 SHALL produce the same result as non-aliased registers (each chunk read before its own write).
REQ-020 Latency: accept at edge T, done=1 during cycle after edge T+NBEAT, i.e. NBEAT+1 cycles from accept to done.
REQ-021 busy SHALL be 1 in EXEC and DONE, 0 in IDLE.
REQ-022 Illegal opcode SHALL perform no register write, still traverse EXEC for NBEAT beats, and assert err with done.
REQ-023 Host write SHALL take effect at the clock edge when wr_en=1 and state is IDLE and no accept that same cycle.
REQ-024 wr_en while busy, or coincident with an accept, SHALL be dropped and wr_drop pulsed the following cycle.
REQ-025 rd_data SHALL be registered: value of register rd_addr one cycle after rd_addr presented, reflecting writes completed at prior edges.
REQ-026 Back-to-back instructions: inst_ready rises in the cycle after done; earliest next accept one cycle after done.

Reset
REQ-027 On rst: state IDLE, busy=0, done=0, err=0, wr_drop=0, inst_ready=1 after release, rd_data=0, beat counter=0.
REQ-028 Register file contents SHALL reset to all zeros.
REQ-029 rst mid-EXEC SHALL abort immediately; lanes already written keep no guarantee other than the reset-to-zero of REQ-028; no done pulse.

Structure
REQ-030 Opcode enum (OP_MAX, OP_MIN, OP_RELU, OP_ILL) and FSM state enum SHALL live in shared package cnn_isa_pkg.
REQ-031 One sub-module SHALL be instantiated: vmax_lane (combinational DATA_W-bit signed max/min/relu for one lane), generated PAR times.
REQ-032 Register file SHALL be internal flops, one write path per beat of PAR lanes plus host full-vector write.

Verification
REQ-033 Load r1 all lanes 5, r2 all lanes -3; MAX r1,r2->r3 -> r3 all 5, done at accept+5 (defaults NBEAT=4).
REQ-034 Load r1 lane i = i-16, RELU r1->r1 -> lanes 0..15 = 0, lanes 16..31 = 0..15 (aliasing).
REQ-035 MIN with r1=r2 lane values 0x8000 and 0x7FFF -> result 0x8000 per lane; ties return src1.
REQ-036 Opcode 11 -> no register changed, err=1 with done, busy high 5 cycles.
REQ-037 wr_en asserted 2 cycles after accept -> wr_drop pulses, target register unchanged.
REQ-038 rst asserted at EXEC beat 2 -> busy=0, inst_ready=1 after release, all registers read 0.
